// File: rtl/cla_operand_sequencer.sv
// cla_operand_sequencer: queues operand pairs and steps each through an external combinational adder.
module cla_operand_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  input  logic [WIDTH-1:0]         S,
  input  logic                     C,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic push, pop;
  assign in_ready = int'(fifo_count) < DEPTH;
  assign push = in_valid && in_ready;
  assign pop = (state == IDLE) && (fifo_count != '0);
  always_comb begin
    state_nx = pop ? DRIVE : (state == DRIVE) ? HOLD : (state == HOLD && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wptr] <= in_a;
      fifo_b[wptr] <= in_b;
    end
  end
  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
      B <= '0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (pop) begin
        A <= fifo_a[rptr];
        B <= fifo_b[rptr];
      end
      if (state == DRIVE) begin
        out_sum <= S;
        out_cout <= C;
      end
      out_valid <= state_nx == HOLD;
    end
  end
endmodule

// File: tb/tb_cla_operand_sequencer.sv
// tb_cla_operand_sequencer: directed checks of queueing, sequencing, backpressure and reset.
module tb_cla_operand_sequencer;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, C, out_valid, out_ready, out_cout;
  logic [31:0] in_a, in_b, A, B, S, out_sum;
  logic [2:0] fifo_count;
  int checks = 0;
  int errors = 0;

  cla_operand_sequencer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .A(A), .B(B), .S(S), .C(C),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .fifo_count(fifo_count)
  );

  // downstream combinational adder
  assign {C, S} = {1'b0, A} + {1'b0, B};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, fifo_count, in_ready, out_cout} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_ctrl got v=%b cnt=%0d rdy=%b c=%b exp v=0 cnt=0 rdy=1 c=0", out_valid, fifo_count, in_ready, out_cout);
    end
    checks++;
    if ({A, B, out_sum} !== 96'd0) begin
      errors++; $display("FAIL reset_data got A=%h B=%h sum=%h exp all 0", A, B, out_sum);
    end
    step(); step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_a = 32'd1; in_b = 32'd2; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++; $display("FAIL first_push got cnt=%0d exp 1", fifo_count);
    end
    step(); step();
    checks++;
    if ({out_valid, out_sum} !== {1'b1, 32'd3}) begin
      errors++; $display("FAIL first_result got v=%b sum=%h exp v=1 sum=3", out_valid, out_sum);
    end
    step();
  endtask

  task automatic test_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] es, input logic ec);
    out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
    checks++;
    if ({fifo_count, out_valid} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL pair_accept got cnt=%0d v=%b exp cnt=1 v=0", fifo_count, out_valid);
    end
    step();
    checks++;
    if ({A, B, out_valid, fifo_count} !== {a, b, 1'b0, 3'd0}) begin
      errors++; $display("FAIL pair_pop got A=%h B=%h v=%b cnt=%0d exp A=%h B=%h v=0 cnt=0", A, B, out_valid, fifo_count, a, b);
    end
    step();
    checks++;
    if ({out_valid, out_sum, out_cout} !== {1'b1, es, ec}) begin
      errors++; $display("FAIL pair_result got v=%b sum=%h c=%b exp v=1 sum=%h c=%b", out_valid, out_sum, out_cout, es, ec);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pair_release got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_throughput();
    logic [31:0] ta [3] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030};
    int cyc = 0;
    int n = 0;
    out_ready = 1'b1;
    while (n < 3 && cyc < 30) begin
      in_valid = cyc < 3;
      in_a = ta[cyc % 3]; in_b = 32'd5;
      step();
      cyc++;
      if (out_valid) begin
        checks++;
        if (out_sum !== ta[n] + 32'd5 || cyc != 3 * (n + 1)) begin
          errors++; $display("FAIL throughput got sum=%h cycle=%0d exp sum=%h cycle=%0d", out_sum, cyc, ta[n] + 32'd5, 3 * (n + 1));
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL throughput_count got %0d exp 3", n);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] ba [6];
    logic [32:0] be [6];
    int n = 0;
    for (int i = 0; i < 6; i++) begin
      ba[i] = 32'h1111_1111 * (i + 1);
      be[i] = {1'b0, ba[i]} + 33'h0_F000_0000;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = ba[i]; in_b = 32'hF000_0000;
      checks++;
      if (in_ready !== (i < 5)) begin
        errors++; $display("FAIL bp_ready push%0d got %b exp %b", i, in_ready, i < 5);
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if ({fifo_count, in_ready} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL bp_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", fifo_count, in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({out_valid, out_cout, out_sum, A, fifo_count} !== {1'b1, be[0], ba[0], 3'd4}) begin
        errors++; $display("FAIL bp_hold cycle%0d got v=%b sum=%h A=%h cnt=%0d exp v=1 sum=%h A=%h cnt=4", i, out_valid, out_sum, A, fifo_count, be[0][31:0], ba[0]);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        checks++;
        if (n >= 5) begin
          errors++; $display("FAIL bp_extra got sum=%h exp no result", out_sum);
        end else if ({out_cout, out_sum} !== be[n]) begin
          errors++; $display("FAIL bp_order result%0d got %h exp %h", n, {out_cout, out_sum}, be[n]);
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 5 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL bp_drain got n=%0d cnt=%0d exp n=5 cnt=0", n, fifo_count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wa [10];
    logic [32:0] we [10];
    int pi = 0;
    int ri = 0;
    int cyc = 0;
    logic acc, got;
    for (int i = 0; i < 10; i++) begin
      wa[i] = 32'h9E37_79B9 * (i + 1);
      we[i] = {1'b0, wa[i]} + {1'b0, 32'h7F00_0000 + 32'(i)};
    end
    while (ri < 10 && cyc < 400) begin
      in_valid = pi < 10;
      in_a = wa[pi % 10]; in_b = 32'h7F00_0000 + 32'(pi);
      out_ready = 1'($urandom_range(0, 1));
      #0;
      acc = in_valid && in_ready;
      got = out_valid && out_ready;
      if (got) begin
        checks++;
        if ({out_cout, out_sum} !== we[ri]) begin
          errors++; $display("FAIL wrap_order result%0d got %h exp %h", ri, {out_cout, out_sum}, we[ri]);
        end
      end
      step();
      cyc++;
      if (acc) pi++;
      if (got) ri++;
    end
    in_valid = 1'b0;
    checks++;
    if (ri != 10 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL wrap_done got results=%0d cnt=%0d exp results=10 cnt=0", ri, fifo_count);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h100 * (i + 1); in_b = 32'd7;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, fifo_count, out_sum} !== {1'b1, 3'd2, 32'h107}) begin
      errors++; $display("FAIL rh_before got v=%b cnt=%0d sum=%h exp v=1 cnt=2 sum=107", out_valid, fifo_count, out_sum);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, fifo_count, in_ready, A, out_sum} !== {1'b0, 3'd0, 1'b1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL rh_async got v=%b cnt=%0d rdy=%b A=%h sum=%h exp v=0 cnt=0 rdy=1 A=0 sum=0", out_valid, fifo_count, in_ready, A, out_sum);
    end
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({out_valid, fifo_count} !== {1'b0, 3'd0}) begin
        errors++; $display("FAIL rh_quiet cycle%0d got v=%b cnt=%0d exp v=0 cnt=0", i, out_valid, fifo_count);
      end
    end
    in_valid = 1'b1; in_a = 32'h8ED5_6AC8; in_b = 32'h7DA6_62A9;
    step();
    in_valid = 1'b0;
    step(); step();
    checks++;
    if ({out_valid, out_sum, out_cout} !== {1'b1, 32'h0C7B_CD71, 1'b1}) begin
      errors++; $display("FAIL rh_new got v=%b sum=%h c=%b exp v=1 sum=0c7bcd71 c=1", out_valid, out_sum, out_cout);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_pair(32'h8ED5_6AC8, 32'h7DA6_62A9, 32'h0C7B_CD71, 1'b1);
    test_pair(32'h2EEA_AAC8, 32'h56A6_7559, 32'h8591_2021, 1'b0);
    test_pair(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    test_pair(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    test_throughput();
    test_backpressure();
    test_wrap();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
